// File: rtl/cpu_rst_gen.sv
// Reset sequencer: async-assert / sync-release CPU reset with stretch, SW reset handshake and cause tracking.
// Optional watchdog reset enabled by defining CPU_RST_GEN_WDT_EN (adds the wdt_kick port).
module cpu_rst_gen #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned WDT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_rst_req,
    output logic       sw_rst_ack,
    output logic       rst,
    output logic       rst_done,
    output logic [1:0] rst_cause
`ifdef CPU_RST_GEN_WDT_EN
    ,
    input  logic       wdt_kick
`endif
);

    localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;

    // Reject out-of-range configurations at elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RST_CYCLES < 1 || RST_CYCLES > 65535 ||
        WDT_CYCLES < 1) begin : g_param_check
        $error("cpu_rst_gen: illegal parameter value");
    end

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        STRETCH = 2'b01,
        RUN     = 2'b10,
        SW_ACK  = 2'b11
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;

`ifdef CPU_RST_GEN_WDT_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(WDT_CYCLES - 1);
    localparam logic [1:0]       CAUSE_WDT = 2'b10;

    logic [WDT_W-1:0] wdt_cnt;
`endif

    // Sequencer: release only after the synchronizer fills and the stretch expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            sync       <= '0;
            cnt        <= '0;
            rst        <= 1'b1;
            sw_rst_ack <= 1'b0;
            rst_done   <= 1'b0;
            rst_cause  <= CAUSE_POR;
`ifdef CPU_RST_GEN_WDT_EN
            wdt_cnt    <= '0;
`endif
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], 1'b1};
            sw_rst_ack <= 1'b0;
            rst_done   <= 1'b0;
            case (state)
                HOLD: begin
                    if (sync[SYNC_STAGES-1]) begin
                        state <= STRETCH;
                        cnt   <= '0;
                    end
                end
                STRETCH: begin
                    if (cnt == CNT_LAST) begin
                        state    <= RUN;
                        rst      <= 1'b0;
                        rst_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    // SW request outranks a simultaneous watchdog expiry.
                    if (sw_rst_req) begin
                        state      <= SW_ACK;
                        rst        <= 1'b1;
                        sw_rst_ack <= 1'b1;
                        rst_cause  <= CAUSE_SW;
`ifdef CPU_RST_GEN_WDT_EN
                        wdt_cnt    <= '0;
                    end else if (wdt_kick) begin
                        wdt_cnt <= '0;
                    end else if (wdt_cnt == WDT_LAST) begin
                        state     <= STRETCH;
                        cnt       <= '0;
                        rst       <= 1'b1;
                        rst_cause <= CAUSE_WDT;
                        wdt_cnt   <= '0;
                    end else begin
                        wdt_cnt <= wdt_cnt + WDT_W'(1);
`endif
                    end
                end
                SW_ACK: begin
                    state <= STRETCH;
                    cnt   <= '0;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_rst_gen.sv
// Self-checking bench for cpu_rst_gen: a countdown reference model predicts outputs per edge,
// expected vectors go through a scoreboard queue and are compared after each rising edge.
module tb_cpu_rst_gen;

    localparam int unsigned S = 2;
    localparam int unsigned R = 16;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic       rst;
        logic       ack;
        logic       done;
        logic [1:0] cause;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       sw_rst_ack;
    logic       rst;
    logic       rst_done;
    logic [1:0] rst_cause;
`ifdef CPU_RST_GEN_WDT_EN
    logic       wdt_kick = 1'b0;
`endif

    always #5 clk = ~clk;

    cpu_rst_gen #(
        .SYNC_STAGES(S),
        .RST_CYCLES (R),
        .WDT_CYCLES (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .sw_rst_ack(sw_rst_ack),
        .rst       (rst),
        .rst_done  (rst_done),
        .rst_cause (rst_cause)
`ifdef CPU_RST_GEN_WDT_EN
        ,
        .wdt_kick  (wdt_kick)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    // Reference model: edges remaining until rst falls, plus watchdog count.
    logic       m_rst;
    logic       m_ack;
    logic       m_done;
    logic [1:0] m_cause;
    logic       m_run;
    int         m_down;
    int         m_wdt;

    task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {rst,ack,done,cause}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rst   = 1'b1;
        m_ack   = 1'b0;
        m_done  = 1'b0;
        m_cause = 2'b00;
        m_run   = 1'b0;
        m_down  = S + R + 1;
        m_wdt   = 0;
    endtask

    task automatic model_edge(input logic req);
        m_ack  = 1'b0;
        m_done = 1'b0;
        if (!m_run) begin
            m_down--;
            if (m_down == 0) begin
                m_run  = 1'b1;
                m_rst  = 1'b0;
                m_done = 1'b1;
                m_wdt  = 0;
            end
        end else if (req) begin
            m_run   = 1'b0;
            m_rst   = 1'b1;
            m_ack   = 1'b1;
            m_cause = 2'b01;
            m_down  = R + 1;
`ifdef CPU_RST_GEN_WDT_EN
        end else if (wdt_kick) begin
            m_wdt = 0;
        end else if (m_wdt == W - 1) begin
            m_run   = 1'b0;
            m_rst   = 1'b1;
            m_cause = 2'b10;
            m_down  = R;
        end else begin
            m_wdt++;
`endif
        end
    endtask

    // One clock: drive at negedge, predict, push; compare after the rising edge.
    task automatic step(input logic req);
        exp_t e;
        @(negedge clk);
        sw_rst_req = req;
        if (!rst_n) model_reset();
        else model_edge(req);
        e.rst   = m_rst;
        e.ack   = m_ack;
        e.done  = m_done;
        e.cause = m_cause;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check_vec($sformatf("cyc%0d", cyc), {rst, sw_rst_ack, rst_done, rst_cause}, e);
    endtask

`ifdef CPU_RST_GEN_WDT_EN
    task automatic kstep(input logic req, input logic kick);
        wdt_kick = kick;
        step(req);
    endtask
`endif

    // Assert rst_n between edges (called just after a step); optionally release before the next edge.
    task automatic async_rst(input bit glitch);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_vec("async_assert", {rst, sw_rst_ack, rst_done, rst_cause},
                  {m_rst, m_ack, m_done, m_cause});
        if (glitch) begin
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Power-on: hold 5 cycles, release, rst falls on edge 19
        repeat (5) step(1'b0);
        rst_n = 1'b1;
        repeat (25) step(1'b0);

        // Software reset: one-cycle request in RUN
        step(1'b1);
        repeat (24) step(1'b0);

        // Request during STRETCH is ignored
        async_rst(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        repeat (8) step(1'b0);
        repeat (5) step(1'b1);
        repeat (12) step(1'b0);

        // Reset re-asserted mid-stretch restarts the sequence
        async_rst(1'b0);
        rst_n = 1'b1;
        repeat (10) step(1'b0);
        async_rst(1'b0);
        repeat (2) step(1'b0);
        rst_n = 1'b1;
        repeat (22) step(1'b0);

        // Sub-cycle glitch after a SW reset: full reset, cause back to POR
        step(1'b1);
        repeat (5) step(1'b0);
        async_rst(1'b1);
        repeat (22) step(1'b0);

        // Request held high: each RUN entry sees a fresh request
        repeat (40) step(1'b1);
        repeat (20) step(1'b0);

`ifdef CPU_RST_GEN_WDT_EN
        // Watchdog expiry with no kick
        async_rst(1'b0);
        rst_n = 1'b1;
        repeat (19) kstep(1'b0, 1'b0);
        repeat (30) kstep(1'b0, 1'b0);
        for (int i = 0; i < 40 && !m_run; i++) kstep(1'b0, 1'b0);
        // Regular kicks keep the CPU running
        for (int i = 0; i < 100; i++) kstep(1'b0, (i % 7) == 6);
        // Kick on the expiry cycle wins
        for (int i = 0; i < 20 && !(m_run && m_wdt == W - 1); i++) kstep(1'b0, 1'b0);
        kstep(1'b0, 1'b1);
        // SW request on the expiry cycle wins
        for (int i = 0; i < 20 && !(m_run && m_wdt == W - 1); i++) kstep(1'b0, 1'b0);
        kstep(1'b1, 1'b0);
        repeat (20) kstep(1'b0, 1'b0);
`endif

        check_vec("sb_drain", 5'(exp_q.size()), 5'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
